addr_stack_array: RTL and testbench

- Parametrised successor of the 4004 program-counter/stack array.
- Holds DEPTH address registers of 4*NIBBLES bits; the row selected by the stack pointer is the active program counter.
- Nibble-serial load, read and increment over a 4-bit bus, the same datapath style as the MCS-4 core.
- Synchronous to sysclk; a command valid/ready handshake replaces the clk1/clk2 phase decode.

---
 rtl/addr_stack_pkg.sv | 21 ++
 rtl/addr_stack_array_nibble_incr.sv | 14 +
 rtl/addr_stack_array.sv | 151 +++++++++++++++
 tb/tb_addr_stack_array.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_stack_pkg.sv
// Shared constants for the nibble-serial address stack: command opcodes,
// FSM state encoding and bus width.
package addr_stack_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_LOAD = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd3;
  localparam logic [2:0] CMD_RET  = 3'd4;
  localparam logic [2:0] CMD_READ = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_INC,
    ST_RD
  } state_t;

endpackage

// File: rtl/addr_stack_array_nibble_incr.sv
// Combinational 4-bit incrementer slice: nibble plus carry-in gives sum and
// carry-out. Shared by every step of the serial INC operation.
module nibble_incr
  import addr_stack_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  assign {cout, sum} = {1'b0, a} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/addr_stack_array.sv
// Parametrised 4004-style PC/stack array with nibble-serial load, increment
// and read. Optional ADDR_STACK_GUARD_EN adds sticky overflow/underflow flags.
module addr_stack_array
  import addr_stack_pkg::*;
#(
  parameter int NIBBLES = 3,
  parameter int DEPTH   = 4
) (
  input  logic                          sysclk,
  input  logic                          poc_n,
  input  logic                          cmd_valid,
  input  logic [2:0]                    cmd,
  output logic                          cmd_ready,
  input  logic [NIBBLE_W-1:0]           din,
  output logic [NIBBLE_W-1:0]           dout,
  output logic                          dout_valid,
  output logic [$clog2(DEPTH)-1:0]      level,
  output logic [NIBBLE_W*NIBBLES-1:0]   pc,
  output logic                          ovf,
  output logic                          udf
);

  localparam int AW = NIBBLE_W * NIBBLES;
  localparam int LW = $clog2(DEPTH);
  localparam logic [2:0]    NC_LAST = 3'(NIBBLES - 1);
  localparam logic [LW-1:0] LVL_TOP = LW'(DEPTH - 1);

  state_t state, state_nx;
  logic [AW-1:0]       rows [DEPTH];
  logic [2:0]          nc;
  logic                carry;
  logic                accept;
  logic                nc_last;
  logic [NIBBLE_W-1:0] cur_nib;
  logic [NIBBLE_W-1:0] inc_sum;
  logic                inc_cout;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign nc_last   = (nc == NC_LAST);
  assign pc        = rows[level];
  assign cur_nib   = pc[nc*NIBBLE_W +: NIBBLE_W];

  nibble_incr u_incr (
    .a    (cur_nib),
    .cin  (carry),
    .sum  (inc_sum),
    .cout (inc_cout)
  );

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_INC:            state_nx = ST_INC;
            CMD_LOAD, CMD_CALL: state_nx = ST_WR;
            CMD_READ:           state_nx = ST_RD;
            default:            state_nx = ST_IDLE;
          endcase
        end
      end
      ST_WR, ST_INC, ST_RD: if (nc_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // dout is loaded at accept so the first nibble is valid the cycle after;
  // each RD step then prefetches the next nibble.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) rows[i] <= '0;
      level      <= '0;
      nc         <= '0;
      carry      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          nc <= '0;
          if (accept) begin
            case (cmd)
              CMD_INC:  carry <= 1'b1;
              CMD_CALL: level <= level + LW'(1);
              CMD_RET:  level <= level - LW'(1);
              CMD_READ: begin
                dout       <= pc[NIBBLE_W-1:0];
                dout_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WR: begin
          rows[level][nc*NIBBLE_W +: NIBBLE_W] <= din;
          nc <= nc_last ? '0 : nc + 3'd1;
        end
        ST_INC: begin
          rows[level][nc*NIBBLE_W +: NIBBLE_W] <= inc_sum;
          carry <= inc_cout;
          nc    <= nc_last ? '0 : nc + 3'd1;
        end
        ST_RD: begin
          if (nc_last) dout_valid <= 1'b0;
          else         dout <= pc[(nc + 3'd1)*NIBBLE_W +: NIBBLE_W];
          nc <= nc_last ? '0 : nc + 3'd1;
        end
        default: nc <= '0;
      endcase
    end
  end

`ifdef ADDR_STACK_GUARD_EN
  localparam int DW = $clog2(DEPTH + 1);

  logic [DW-1:0] depth_cnt;
  logic          ovf_q;
  logic          udf_q;

  // depth_cnt saturating at DEPTH marks a push that would bury the oldest row
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      depth_cnt <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else if (accept) begin
      if (cmd == CMD_CALL) begin
        if (level == LVL_TOP || depth_cnt == DW'(DEPTH)) ovf_q <= 1'b1;
        if (depth_cnt != DW'(DEPTH)) depth_cnt <= depth_cnt + DW'(1);
      end else if (cmd == CMD_RET) begin
        if (level == '0) udf_q <= 1'b1;
        if (depth_cnt != '0) depth_cnt <= depth_cnt - DW'(1);
      end
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_addr_stack_array.sv
// Self-checking bench for addr_stack_array (NIBBLES=3, DEPTH=4) against an
// integer-level stack model; flag expectations follow ADDR_STACK_GUARD_EN.
module tb_addr_stack_array;
  import addr_stack_pkg::*;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int AW = 4 * N;
  localparam int LW = $clog2(D);
`ifdef ADDR_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          sysclk;
  logic          poc_n;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic          cmd_ready;
  logic [3:0]    din;
  logic [3:0]    dout;
  logic          dout_valid;
  logic [LW-1:0] level;
  logic [AW-1:0] pc;
  logic          ovf;
  logic          udf;

  addr_stack_array #(.NIBBLES(N), .DEPTH(D)) dut (
    .sysclk     (sysclk),
    .poc_n      (poc_n),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .level      (level),
    .pc         (pc),
    .ovf        (ovf),
    .udf        (udf)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: a plain array of addresses and an integer pointer
  logic [AW-1:0] m_rows [D];
  int            m_level;
  bit            m_ovf;
  bit            m_udf;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_rows[i] = '0;
    m_level = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endfunction

  function automatic void model_accept(input logic [2:0] c);
    case (c)
      CMD_INC: m_rows[m_level] = m_rows[m_level] + AW'(1);
      CMD_CALL: begin
        if (m_level == D - 1) m_ovf = 1'b1;
        m_level = (m_level + 1) % D;
      end
      CMD_RET: begin
        if (m_level == 0) m_udf = 1'b1;
        m_level = (m_level + D - 1) % D;
      end
      default: ;
    endcase
  endfunction

  // Waits (bounded) for idle, presents one command for one accepting edge
  task automatic issue(input logic [2:0] c);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge sysclk); #1;
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_timeout cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd       = c;
    @(posedge sysclk); #1;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    model_accept(c);
  endtask

  task automatic write_op(input logic [2:0] c, input logic [AW-1:0] data);
    issue(c);
    for (int i = 0; i < N; i++) begin
      din = data[i*4 +: 4];
      @(posedge sysclk); #1;
    end
    m_rows[m_level] = data;
  endtask

  task automatic inc_op();
    issue(CMD_INC);
    repeat (N) begin
      @(posedge sysclk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (cmd_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== 4'h0) begin
      errors++;
      $display("FAIL reset_handshake ready=%b dv=%b dout=%h required 1 0 0", cmd_ready, dout_valid, dout);
    end
    checks++;
    if (level !== '0 || pc !== '0 || ovf !== 1'b0 || udf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state level=%0d pc=%h ovf=%b udf=%b required 0 000 0 0", level, pc, ovf, udf);
    end
    @(posedge sysclk); #1;
    poc_n = 1'b1;
    model_reset();
  endtask

  task automatic test_load();
    issue(CMD_LOAD);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_busy cycle=%0d ready=%b required 0", i, cmd_ready);
      end
      din = (i == 0) ? 4'h5 : (i == 1) ? 4'hA : 4'h3;
      @(posedge sysclk); #1;
    end
    m_rows[m_level] = 12'h3A5;
    checks++;
    if (pc !== 12'h3A5 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_result pc=%h ready=%b required 3a5 1", pc, cmd_ready);
    end
  endtask

  task automatic test_inc();
    write_op(CMD_LOAD, 12'h0FF);
    inc_op();
    checks++;
    if (pc !== 12'h100 || pc !== m_rows[m_level]) begin
      errors++;
      $display("FAIL inc_carry pc=%h required 100", pc);
    end
    write_op(CMD_LOAD, 12'hFFF);
    inc_op();
    checks++;
    if (pc !== 12'h000 || ovf !== 1'b0 || udf !== 1'b0) begin
      errors++;
      $display("FAIL inc_wrap pc=%h ovf=%b udf=%b required 000 0 0", pc, ovf, udf);
    end
  endtask

  task automatic test_call_ret();
    write_op(CMD_LOAD, 12'h123);
    write_op(CMD_CALL, 12'h456);
    checks++;
    if (level !== LW'(1) || pc !== 12'h456) begin
      errors++;
      $display("FAIL call level=%0d pc=%h required 1 456", level, pc);
    end
    issue(CMD_RET);
    checks++;
    if (level !== LW'(0) || pc !== 12'h123 || dut.rows[1] !== 12'h456) begin
      errors++;
      $display("FAIL ret level=%0d pc=%h row1=%h required 0 123 456", level, pc, dut.rows[1]);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] v;
    for (int k = 1; k <= 4; k++) begin
      v = AW'(k * 12'h111);
      write_op(CMD_CALL, v);
    end
    checks++;
    if (level !== LW'(0) || pc !== 12'h444 || ovf !== GUARD || udf !== 1'b0) begin
      errors++;
      $display("FAIL call_wrap level=%0d pc=%h ovf=%b udf=%b required 0 444 %b 0", level, pc, ovf, udf, GUARD);
    end
    issue(CMD_RET);
    checks++;
    if (level !== LW'(3) || pc !== 12'h333 || udf !== GUARD || ovf !== GUARD) begin
      errors++;
      $display("FAIL ret_wrap level=%0d pc=%h udf=%b ovf=%b required 3 333 %b %b", level, pc, udf, ovf, GUARD, GUARD);
    end
  endtask

  task automatic test_read();
    logic [3:0] exp_n;
    logic [AW-1:0] v;
    write_op(CMD_LOAD, 12'hABC);
    v = 12'hABC;
    issue(CMD_READ);
    for (int i = 0; i < N; i++) begin
      exp_n = v[i*4 +: 4];
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_n || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL read_nibble%0d dv=%b dout=%h ready=%b required 1 %h 0", i, dout_valid, dout, cmd_ready, exp_n);
      end
      cmd_valid = 1'b1;
      cmd       = CMD_INC;
      @(posedge sysclk); #1;
      cmd_valid = 1'b0;
      cmd       = CMD_NOP;
    end
    checks++;
    if (dout_valid !== 1'b0 || dout !== 4'hA || pc !== 12'hABC || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_end dv=%b dout=%h pc=%h ready=%b required 0 a abc 1", dout_valid, dout, pc, cmd_ready);
    end
  endtask

  task automatic test_random(input int count);
    logic [2:0]    c;
    logic [AW-1:0] data;
    logic [AW-1:0] exp_row;
    for (int k = 0; k < count; k++) begin
      c    = 3'($urandom_range(0, 7));
      data = AW'($urandom);
      case (c)
        CMD_LOAD, CMD_CALL: write_op(c, data);
        CMD_INC: inc_op();
        CMD_READ: begin
          issue(CMD_READ);
          exp_row = m_rows[m_level];
          for (int i = 0; i < N; i++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== exp_row[i*4 +: 4]) begin
              errors++;
              $display("FAIL rand_read op=%0d nib=%0d dv=%b dout=%h required 1 %h", k, i, dout_valid, dout, exp_row[i*4 +: 4]);
            end
            cmd_valid = 1'($urandom_range(0, 1));
            cmd       = 3'($urandom_range(0, 7));
            @(posedge sysclk); #1;
            cmd_valid = 1'b0;
            cmd       = CMD_NOP;
          end
          checks++;
          if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_read_end op=%0d dv=%b required 0", k, dout_valid);
          end
        end
        default: issue(c);
      endcase
      checks++;
      if (pc !== m_rows[m_level] || level !== LW'(m_level) || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_state op=%0d cmd=%0d pc=%h level=%0d ready=%b required %h %0d 1", k, c, pc, level, cmd_ready, m_rows[m_level], m_level);
      end
      checks++;
      if (ovf !== (GUARD & m_ovf) || udf !== (GUARD & m_udf)) begin
        errors++;
        $display("FAIL rand_flags op=%0d ovf=%b udf=%b required %b %b", k, ovf, udf, GUARD & m_ovf, GUARD & m_udf);
      end
    end
  endtask

  task automatic test_reset_mid_wr();
    write_op(CMD_CALL, 12'h9E7);
    issue(CMD_LOAD);
    din = 4'hD;
    @(posedge sysclk); #1;
    din = 4'h6;
    #1 poc_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pc !== '0 || level !== '0 || cmd_ready !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_wr_reset pc=%h level=%0d ready=%b dv=%b required 000 0 1 0", pc, level, cmd_ready, dout_valid);
    end
    for (int r = 0; r < D; r++) begin
      checks++;
      if (dut.rows[r] !== '0) begin
        errors++;
        $display("FAIL mid_wr_row%0d value=%h required 000", r, dut.rows[r]);
      end
    end
    poc_n = 1'b1;
    @(posedge sysclk); #1;
  endtask

  initial begin
    poc_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    din       = 4'h0;
    model_reset();
    test_reset();
    test_load();
    test_inc();
    test_call_ret();
    test_wrap();
    test_read();
    test_random(120);
    test_reset_mid_wr();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
